spi_dac_receiver: RTL and testbench

- SPI responder (slave) for the serial DAC link driven by the team's DAC transmitter. It deserializes each chip-select frame into a 4-bit control nibble and a 12-bit sample.
- Used as a synthesizable DAC stand-in for loopback testing, and as a board-to-board audio link receiver.
- The SPI pins are asynchronous to clk: they are oversampled and synchronized, and completed frames are presented as a one-cycle valid pulse.

---
 rtl/spi_dac_receiver.sv | 117 +++++++++++
 tb/tb_spi_dac_receiver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dac_receiver.sv
// SPI responder for the serial DAC link: oversamples cs_b/sclk/sdi, deserializes
// each chip-select frame into a control nibble plus a sample, and flags malformed frames.
module spi_dac_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_BITS   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic                            cs_b,
    input  logic                            sclk,
    input  logic                            sdi,
    output logic [FRAME_BITS-DATA_BITS-1:0] ctrl,
    output logic [DATA_BITS-1:0]            data,
    output logic                            valid,
    output logic                            frame_err,
    output logic                            busy
);
    localparam int         CTRL_BITS = FRAME_BITS - DATA_BITS;
    localparam logic [4:0] CNT_FULL  = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT   = 5'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   cs_s, sclk_s, sdi_s;
    logic                   cs_fall, cs_rise, sclk_rise;

    state_e                 state_q;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [4:0]             cnt_q;
    logic [CTRL_BITS-1:0]   ctrl_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, err_q, busy_q;

    // Idle levels (cs_b and sclk high) on reset, so release cannot fake an edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage take the old value of its predecessor.
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_b};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = !cs_s && cs_prev_q;
    assign cs_rise   = cs_s && !cs_prev_q;
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign shift_d   = {shift_q[FRAME_BITS-2:0], sdi_s};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            // NOTE: the whole datapath is reset so an aborted frame can leave nothing behind.
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Chip-select release wins over a coincident sclk edge.
                    if (cs_rise) begin
                        busy_q  <= 1'b0;
                        state_q <= CHECK;
                    end else if (sclk_rise) begin
                        shift_q <= shift_d;
                        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 5'd1;
                    end
                end
                CHECK: begin
                    if (cnt_q == CNT_FULL) begin
                        ctrl_q  <= shift_q[FRAME_BITS-1:DATA_BITS];
                        data_q  <= shift_q[DATA_BITS-1:0];
                        valid_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctrl      = ctrl_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// Bench for spi_dac_receiver: directed and random frames are checked against a
// frame-level model (a frame is good exactly when it carries FRAME_BITS bits).
module tb_spi_dac_receiver;
    localparam int FRAME_BITS  = 16;
    localparam int DATA_BITS   = 12;
    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        cs_b = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic [3:0]  ctrl;
    logic [11:0] data;
    logic        valid, frame_err, busy;

    int n_checks = 0, n_errors = 0;
    int n_valid = 0, n_err = 0, n_overlap = 0, n_busy_bad = 0;
    int cs_high_run = 0, cs_low_run = 0;

    logic [3:0]  exp_ctrl = 4'h0;
    logic [11:0] exp_data = 12'h000;

    always #5 clk = ~clk;

    spi_dac_receiver #(
        .FRAME_BITS (FRAME_BITS),
        .DATA_BITS  (DATA_BITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .cs_b     (cs_b),
        .sclk     (sclk),
        .sdi      (sdi),
        .ctrl     (ctrl),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Pulse counting and busy-vs-pin sanity, sampled away from the active edge.
    always @(negedge clk) begin
        if (cs_b) begin cs_high_run++; cs_low_run = 0; end
        else begin cs_low_run++; cs_high_run = 0; end
        if (reset_b) begin
            if (valid) n_valid++;
            if (frame_err) n_err++;
            if (valid && frame_err) n_overlap++;
            if (busy && cs_high_run > LATENCY + 1) n_busy_bad++;
            if (!busy && cs_low_run > LATENCY + 1) n_busy_bad++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a frame is the bit sequence sent while cs_b is low.
    task automatic model_frame(input logic [63:0] v, input int n,
                               output int want_valid, output int want_err);
        if (n == FRAME_BITS) begin
            exp_ctrl   = v[15:12];
            exp_data   = v[11:0];
            want_valid = 1;
            want_err   = 0;
        end else begin
            want_valid = 0;
            want_err   = 1;
        end
    endtask

    // Lowers cs_b and sends n bits MSB first; sclk = clk/8, sdi moves on sclk fall.
    task automatic start_frame(input logic [63:0] v, input int n);
        @(negedge clk) cs_b = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            sdi = v[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // Raises cs_b and counts rising edges (the one that samples cs_b high is edge 1)
    // until a valid or frame_err pulse is visible; 99 means no pulse in budget.
    task automatic finish_frame(output int lat);
        bit seen = 1'b0;
        @(negedge clk) cs_b = 1'b1;
        lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid || frame_err) seen = 1'b1;
        end
        if (!seen) lat = 99;
    endtask

    task automatic run_frame(input logic [63:0] v, input int n,
                             output int dv, output int de, output int lat);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        start_frame(v, n);
        finish_frame(lat);
        repeat (8) @(negedge clk);
        dv = n_valid - v0;
        de = n_err - e0;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ctrl !== 4'h0) begin n_errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
        n_checks++; if (data !== 12'h000) begin n_errors++; $display("FAIL reset_data: got %h expected 000", data); end
        n_checks++; if (valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_short_frame();
        int dv, de, lat, wv, we;
        model_frame(64'h3FFE >> 1, 15, wv, we);
        run_frame(64'h3FFE >> 1, 15, dv, de, lat);
        n_checks++; if (dv !== wv) begin n_errors++; $display("FAIL short_valid: got %0d pulses expected %0d", dv, wv); end
        n_checks++; if (de !== we) begin n_errors++; $display("FAIL short_err: got %0d pulses expected %0d", de, we); end
        n_checks++; if ({ctrl, data} !== {exp_ctrl, exp_data}) begin n_errors++; $display("FAIL short_hold: got %h/%h expected %h/%h", ctrl, data, exp_ctrl, exp_data); end
    endtask

    task automatic test_good_frame();
        int dv, de, lat, wv, we;
        model_frame(64'h3FFE, 16, wv, we);
        start_frame(64'h3FFE, 16);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL good_busy: got %b expected 1", busy); end
        finish_frame(lat);
        repeat (8) @(negedge clk);
        n_checks++; if (lat !== LATENCY) begin n_errors++; $display("FAIL good_latency: got %0d expected %0d", lat, LATENCY); end
        n_checks++; if (n_valid !== 1) begin n_errors++; $display("FAIL good_valid: got %0d pulses expected 1", n_valid); end
        n_checks++; if (n_err !== 1) begin n_errors++; $display("FAIL good_err: got %0d total err pulses expected 1", n_err); end
        n_checks++; if (ctrl !== 4'h3) begin n_errors++; $display("FAIL good_ctrl: got %h expected 3", ctrl); end
        n_checks++; if (data !== 12'hFFE) begin n_errors++; $display("FAIL good_data: got %h expected FFE", data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL good_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_long_frame();
        int dv, de, lat, wv, we;
        model_frame(64'h1_3FFE, 17, wv, we);
        run_frame(64'h1_3FFE, 17, dv, de, lat);
        n_checks++; if (dv !== wv || de !== we) begin n_errors++; $display("FAIL long_pulses: got valid %0d err %0d expected %0d %0d", dv, de, wv, we); end
        n_checks++; if (data !== exp_data) begin n_errors++; $display("FAIL long_hold: got %h expected %h", data, exp_data); end
    endtask

    task automatic test_zero_frame();
        int dv, de, lat, wv, we;
        model_frame(64'h0, 0, wv, we);
        run_frame(64'h0, 0, dv, de, lat);
        n_checks++; if (dv !== wv || de !== we) begin n_errors++; $display("FAIL zero_pulses: got valid %0d err %0d expected %0d %0d", dv, de, wv, we); end
        n_checks++; if ({ctrl, data} !== {exp_ctrl, exp_data}) begin n_errors++; $display("FAIL zero_hold: got %h/%h expected %h/%h", ctrl, data, exp_ctrl, exp_data); end
    endtask

    task automatic test_saturation();
        int dv, de, lat, wv, we;
        model_frame(64'h0000_A5A5_3C3C, 48, wv, we);
        run_frame(64'h0000_A5A5_3C3C, 48, dv, de, lat);
        n_checks++; if (dv !== wv || de !== we) begin n_errors++; $display("FAIL sat_pulses: got valid %0d err %0d expected %0d %0d", dv, de, wv, we); end
        n_checks++; if ({ctrl, data} !== {exp_ctrl, exp_data}) begin n_errors++; $display("FAIL sat_hold: got %h/%h expected %h/%h", ctrl, data, exp_ctrl, exp_data); end
    endtask

    task automatic test_idle_sclk();
        int v0, e0, busy_seen;
        v0 = n_valid;
        e0 = n_err;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            sdi = 1'($urandom);
            repeat (2) @(negedge clk);
            sclk = ~sclk;
            if (busy) busy_seen++;
        end
        repeat (8) @(negedge clk);
        n_checks++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin n_errors++; $display("FAIL idle_pulses: got valid %0d err %0d expected 0 0", n_valid - v0, n_err - e0); end
        n_checks++; if (busy_seen !== 0) begin n_errors++; $display("FAIL idle_busy: got %0d busy samples expected 0", busy_seen); end
        n_checks++; if ({ctrl, data} !== {exp_ctrl, exp_data}) begin n_errors++; $display("FAIL idle_hold: got %h/%h expected %h/%h", ctrl, data, exp_ctrl, exp_data); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0, dv, de, lat, wv, we;
        start_frame(64'h3A, 8);
        v0 = n_valid;
        e0 = n_err;
        @(negedge clk);
        reset_b = 1'b0;
        cs_b = 1'b1;
        sclk = 1'b0;
        exp_ctrl = 4'h0;
        exp_data = 12'h000;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin n_errors++; $display("FAIL abort_pulses: got valid %0d err %0d expected 0 0", n_valid - v0, n_err - e0); end
        n_checks++; if ({ctrl, data} !== 16'h0000) begin n_errors++; $display("FAIL abort_clear: got %h/%h expected 0/000", ctrl, data); end
        model_frame(64'h3123, 16, wv, we);
        run_frame(64'h3123, 16, dv, de, lat);
        n_checks++; if (dv !== 1 || de !== 0) begin n_errors++; $display("FAIL after_reset_pulses: got valid %0d err %0d expected 1 0", dv, de); end
        n_checks++; if (data !== 12'h123 || ctrl !== 4'h3) begin n_errors++; $display("FAIL after_reset_data: got %h/%h expected 3/123", ctrl, data); end
    endtask

    task automatic test_back_to_back();
        int v0, lat1, lat2, wv, we;
        v0 = n_valid;
        model_frame(64'h3001, 16, wv, we);
        start_frame(64'h3001, 16);
        finish_frame(lat1);
        n_checks++; if (data !== 12'h001) begin n_errors++; $display("FAIL b2b_data1: got %h expected 001", data); end
        n_checks++; if (lat1 !== LATENCY) begin n_errors++; $display("FAIL b2b_lat1: got %0d expected %0d", lat1, LATENCY); end
        model_frame(64'h3800, 16, wv, we);
        start_frame(64'h3800, 16);
        finish_frame(lat2);
        n_checks++; if (data !== 12'h800) begin n_errors++; $display("FAIL b2b_data2: got %h expected 800", data); end
        n_checks++; if (lat2 !== LATENCY) begin n_errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat2, LATENCY); end
        repeat (8) @(negedge clk);
        n_checks++; if (n_valid - v0 !== 2) begin n_errors++; $display("FAIL b2b_count: got %0d pulses expected 2", n_valid - v0); end
    endtask

    task automatic test_random();
        int dv, de, lat, wv, we, n;
        logic [63:0] v;
        for (int i = 0; i < 30; i++) begin
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(13, 19)) : FRAME_BITS;
            v = {32'h0, $urandom};
            model_frame(v, n, wv, we);
            run_frame(v, n, dv, de, lat);
            n_checks++; if (dv !== wv || de !== we) begin n_errors++; $display("FAIL rand_pulses[%0d] n=%0d: got valid %0d err %0d expected %0d %0d", i, n, dv, de, wv, we); end
            n_checks++; if (lat !== LATENCY) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LATENCY); end
            n_checks++; if ({ctrl, data} !== {exp_ctrl, exp_data}) begin n_errors++; $display("FAIL rand_out[%0d]: got %h/%h expected %h/%h", i, ctrl, data, exp_ctrl, exp_data); end
        end
        n_checks++; if (n_overlap !== 0) begin n_errors++; $display("FAIL overlap: got %0d cycles with valid and frame_err expected 0", n_overlap); end
        n_checks++; if (n_busy_bad !== 0) begin n_errors++; $display("FAIL busy_track: got %0d bad busy samples expected 0", n_busy_bad); end
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_good_frame();
        test_long_frame();
        test_zero_frame();
        test_saturation();
        test_idle_sclk();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
